// File: rtl/password_programmer_if.sv
// Keypad-side bundle for the password-change controller: digit strobes and
// requests in, stored password and status flags out.
interface password_programmer_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4
);
    localparam int PW_W = DIGIT_W * NUM_DIGITS;

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_valid;
    logic               set_req;
    logic               cancel;
    logic [PW_W-1:0]    password;
    logic               busy;
    logic [1:0]         phase;
    logic               done;
    logic               error;
    logic               locked;

    modport master (
        output digit_in, digit_valid, set_req, cancel,
        input  password, busy, phase, done, error, locked
    );

    modport slave (
        input  digit_in, digit_valid, set_req, cancel,
        output password, busy, phase, done, error, locked
    );
endinterface

// File: rtl/password_programmer.sv
// Password-change controller: verify old password, take new one twice, commit
// on match. Holds the stored password, with inactivity timeout and lockout.
module password_programmer #(
    parameter int                               DIGIT_W     = 4,
    parameter int                               NUM_DIGITS  = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0]    DEFAULT_PW  = '0,
    parameter int                               TIMEOUT_CYC = 1024,
    parameter int                               MAX_FAIL    = 3,
    parameter int                               LOCK_CYC    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    password_programmer_if.slave bus
);
    localparam int PW_W   = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYC);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_VERIFY, S_ENTER, S_CONFIRM, S_CHECK_V, S_CHECK_C, S_LOCKED
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [PW_W-1:0]     cur_q, cur_d;
    logic [PW_W-1:0]     new_q, new_d;
    logic [PW_W-1:0]     pw_q, pw_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                clear_bufs;
    logic                last_digit;

    // First digit ends up in the MSBs after NUM_DIGITS shifts.
    function automatic logic [PW_W-1:0] shift_digit(input logic [PW_W-1:0] b,
                                                     input logic [DIGIT_W-1:0] d);
        return PW_W'({b, d});
    endfunction

    assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        lock_d     = lock_q;
        fail_d     = fail_q;
        cur_d      = cur_q;
        new_d      = new_q;
        pw_d       = pw_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        clear_bufs = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.set_req) begin
                    state_d    = S_VERIFY;
                    clear_bufs = 1'b1;
                end
            end

            S_VERIFY, S_ENTER, S_CONFIRM: begin
                if (bus.cancel) begin
                    state_d    = S_IDLE;
                    clear_bufs = 1'b1;
                end else if (bus.digit_valid) begin
                    idle_d = '0;
                    if (state_q == S_ENTER) new_d = shift_digit(new_q, bus.digit_in);
                    else                    cur_d = shift_digit(cur_q, bus.digit_in);
                    if (last_digit) begin
                        cnt_d = '0;
                        case (state_q)
                            S_VERIFY: state_d = S_CHECK_V;
                            S_ENTER:  state_d = S_CONFIRM;
                            default:  state_d = S_CHECK_C;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    // Inactivity abort; not counted as a failed verification.
                    state_d    = S_IDLE;
                    error_d    = 1'b1;
                    clear_bufs = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end

            S_CHECK_V: begin
                if (bus.cancel) begin
                    state_d    = S_IDLE;
                    clear_bufs = 1'b1;
                end else if (cur_q == pw_q) begin
                    state_d = S_ENTER;
                    fail_d  = '0;
                    cnt_d   = '0;
                    idle_d  = '0;
                    cur_d   = '0;
                end else begin
                    error_d    = 1'b1;
                    fail_d     = fail_q + 1'b1;
                    clear_bufs = 1'b1;
                    lock_d     = '0;
                    state_d    = (fail_q == FAIL_W'(MAX_FAIL - 1)) ? S_LOCKED : S_IDLE;
                end
            end

            S_CHECK_C: begin
                if (!bus.cancel) begin
                    if (cur_q == new_q) begin
                        pw_d   = new_q;
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                state_d    = S_IDLE;
                clear_bufs = 1'b1;
            end

            S_LOCKED: begin
                if (lock_q == LOCK_W'(LOCK_CYC - 1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end

            default: begin
                state_d    = S_IDLE;
                clear_bufs = 1'b1;
            end
        endcase

        if (clear_bufs) begin
            cnt_d  = '0;
            idle_d = '0;
            cur_d  = '0;
            new_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
            lock_q  <= '0;
            fail_q  <= '0;
            cur_q   <= '0;
            new_q   <= '0;
            pw_q    <= DEFAULT_PW;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            lock_q  <= lock_d;
            fail_q  <= fail_d;
            cur_q   <= cur_d;
            new_q   <= new_d;
            pw_q    <= pw_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        case (state_q)
            S_VERIFY, S_CHECK_V:  bus.phase = 2'd1;
            S_ENTER:              bus.phase = 2'd2;
            S_CONFIRM, S_CHECK_C: bus.phase = 2'd3;
            default:              bus.phase = 2'd0;
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_LOCKED);
    assign bus.locked   = (state_q == S_LOCKED);
    assign bus.password = pw_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
endmodule
